// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared stage definitions for the pipeline hazard controller: forwarding selects,
// trig sequencer states, writeback-source encodings and the stall/flush bundle.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 4;

    typedef enum logic [1:0] {
        REG = 2'b00,
        WB  = 2'b01,
        MEM = 2'b10
    } hazard_fwd_sel;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } trig_state;

    localparam logic [1:0] MTR_ALU  = 2'b00;
    localparam logic [1:0] MTR_DMEM = 2'b01;
    localparam logic [1:0] MTR_PMEM = 2'b10;
    localparam logic [1:0] MTR_TRIG = 2'b11;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic flush_d;
        logic flush_e;
        logic flush_m;
    } hazard_ctrl_signals;

    // The memory stage holds the younger result, so it wins over writeback.
    function automatic hazard_fwd_sel fwd_select(
        input logic                 mem_we,
        input logic [REG_IDX_W-1:0] mem_rd,
        input logic                 wb_we,
        input logic [REG_IDX_W-1:0] wb_rd,
        input logic [REG_IDX_W-1:0] src
    );
        hazard_fwd_sel sel;
        sel = REG;
        if (mem_we && (mem_rd == src)) begin
            sel = MEM;
        end else if (wb_we && (wb_rd == src)) begin
            sel = WB;
        end
        return sel;
    endfunction

    function automatic logic is_mem_load(input logic [1:0] mem_to_reg);
        return (mem_to_reg == MTR_DMEM) || (mem_to_reg == MTR_PMEM);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_trig_seq.sv
// Trig unit sequencer: IDLE/RUN FSM, saturating cycle counter, timeout and
// abort handling, and the pipeline hold request while the trig unit works.
module trig_seq_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int TRIG_TIMEOUT = 64,
    parameter int CNT_W        = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_select,
    input  logic             pc_src,
    input  logic             trig_done,
    output logic             trig_hold,
    output logic             trig_start,
    output logic             trig_abort,
    output logic             trig_error,
    output logic [CNT_W-1:0] trig_cycles
);

    trig_state        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             timeout;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        cyc_d      = cyc_q;
        trig_hold  = 1'b0;
        trig_start = 1'b0;
        trig_abort = 1'b0;
        timeout    = (cnt_q >= CNT_W'(TRIG_TIMEOUT));

        case (state_q)
            IDLE: begin
                if (trig_select && !pc_src) begin
                    state_d    = RUN;
                    cnt_d      = CNT_W'(1);
                    trig_start = 1'b1;
                    trig_hold  = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A branch in writeback kills the operation outright; a real
                // completion beats a coincident timeout.
                if (pc_src) begin
                    state_d    = IDLE;
                    trig_abort = 1'b1;
                end else if (trig_done) begin
                    state_d = IDLE;
                    cyc_d   = cnt_q;
                end else if (timeout) begin
                    state_d    = IDLE;
                    trig_abort = 1'b1;
                    err_d      = 1'b1;
                end else begin
                    trig_hold = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            trig_hold  = 1'b0;
            trig_start = 1'b0;
            trig_abort = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
        end
    end

    assign trig_error  = err_q;
    assign trig_cycles = cyc_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: operand forwarding, load-use detection,
// trig-unit hold and branch flush, merged into the stage stall/flush controls.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int TRIG_TIMEOUT = 64,
    parameter int CNT_W        = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       deco_Rn,
    input  logic [3:0]       deco_Rs,
    input  logic             deco_useRn,
    input  logic             deco_useRs,
    input  logic [3:0]       exe_Rn,
    input  logic [3:0]       exe_Rs,
    input  logic [3:0]       exe_Rd,
    input  logic             exe_regWrite,
    input  logic             exe_trigSelect,
    input  logic [1:0]       exe_memToReg,
    input  logic [3:0]       mem_Rd,
    input  logic [3:0]       wb_Rd,
    input  logic             mem_regWrite,
    input  logic             wb_regWrite,
    input  logic             wb_pcSrc,
    input  logic             trig_done,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             trig_start,
    output logic             trig_abort,
    output logic             trig_error,
    output logic [CNT_W-1:0] trig_cycles
);

    hazard_fwd_sel      fwd_a, fwd_b;
    hazard_ctrl_signals ctrl;
    logic               load_use;
    logic               trig_hold;

    trig_seq_fsm #(
        .TRIG_TIMEOUT(TRIG_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_trig_seq (
        .clk        (clk),
        .rst        (rst),
        .trig_select(exe_trigSelect),
        .pc_src     (wb_pcSrc),
        .trig_done  (trig_done),
        .trig_hold  (trig_hold),
        .trig_start (trig_start),
        .trig_abort (trig_abort),
        .trig_error (trig_error),
        .trig_cycles(trig_cycles)
    );

    always_comb begin
        fwd_a = fwd_select(mem_regWrite, mem_Rd, wb_regWrite, wb_Rd, exe_Rn);
        fwd_b = fwd_select(mem_regWrite, mem_Rd, wb_regWrite, wb_Rd, exe_Rs);

        load_use = exe_regWrite && is_mem_load(exe_memToReg) &&
                   ((deco_useRn && (deco_Rn == exe_Rd)) ||
                    (deco_useRs && (deco_Rs == exe_Rd)));

        ctrl = '0;
        // Branch flush outranks the trig hold, which in turn masks load-use.
        if (rst) begin
            ctrl = '0;
        end else if (wb_pcSrc) begin
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
            ctrl.flush_m = 1'b1;
        end else if (trig_hold) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.flush_m = 1'b1;
        end else if (load_use) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end
    end

    assign stallF = ctrl.stall_f;
    assign stallD = ctrl.stall_d;
    assign stallE = ctrl.stall_e;
    assign flushD = ctrl.flush_d;
    assign flushE = ctrl.flush_e;
    assign flushM = ctrl.flush_m;
    assign fwdA   = fwd_a;
    assign fwdB   = fwd_b;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// stimulus, every cycle compared against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

    localparam int TO    = 64;
    localparam int CNT_W = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [3:0]       deco_Rn, deco_Rs, exe_Rn, exe_Rs, exe_Rd, mem_Rd, wb_Rd;
    logic             deco_useRn, deco_useRs, exe_regWrite, exe_trigSelect;
    logic [1:0]       exe_memToReg;
    logic             mem_regWrite, wb_regWrite, wb_pcSrc, trig_done;
    logic             stallF, stallD, stallE, flushD, flushE, flushM;
    logic [1:0]       fwdA, fwdB;
    logic             trig_start, trig_abort, trig_error;
    logic [CNT_W-1:0] trig_cycles;

    pipeline_hazard_ctrl #(.TRIG_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .deco_Rn(deco_Rn), .deco_Rs(deco_Rs),
        .deco_useRn(deco_useRn), .deco_useRs(deco_useRs),
        .exe_Rn(exe_Rn), .exe_Rs(exe_Rs), .exe_Rd(exe_Rd),
        .exe_regWrite(exe_regWrite), .exe_trigSelect(exe_trigSelect),
        .exe_memToReg(exe_memToReg),
        .mem_Rd(mem_Rd), .wb_Rd(wb_Rd),
        .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite),
        .wb_pcSrc(wb_pcSrc), .trig_done(trig_done),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .fwdA(fwdA), .fwdB(fwdB),
        .trig_start(trig_start), .trig_abort(trig_abort),
        .trig_error(trig_error), .trig_cycles(trig_cycles)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: whether a trig op is outstanding, how many cycles it has
    // been running, the sticky error and the last completed duration.
    bit m_run;
    int m_cnt;
    bit m_err;
    int m_cyc;

    int start_seen, abort_seen, stall_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_fwd(input logic [3:0] src);
        if (mem_regWrite && mem_Rd == src) return 2;
        if (wb_regWrite && wb_Rd == src) return 1;
        return 0;
    endfunction

    task automatic clear_inputs();
        rst = 1'b0;
        {deco_Rn, deco_Rs, exe_Rn, exe_Rs, exe_Rd, mem_Rd, wb_Rd} = '0;
        {deco_useRn, deco_useRs, exe_regWrite, exe_trigSelect} = '0;
        exe_memToReg = 2'b00;
        {mem_regWrite, wb_regWrite, wb_pcSrc, trig_done} = '0;
    endtask

    task automatic sample();
        bit br, hold, lu, st, ab;
        #2;
        br   = !rst && wb_pcSrc;
        hold = !rst && !wb_pcSrc &&
               ((!m_run && exe_trigSelect) || (m_run && !trig_done && m_cnt < TO));
        lu   = !rst && exe_regWrite && (exe_memToReg == 2'd1 || exe_memToReg == 2'd2) &&
               ((deco_useRn && deco_Rn == exe_Rd) || (deco_useRs && deco_Rs == exe_Rd));
        st   = !rst && !m_run && exe_trigSelect && !wb_pcSrc;
        ab   = !rst && m_run && (wb_pcSrc || (!trig_done && m_cnt >= TO));
        check_eq("stallF", 32'(stallF), 32'(!br && (hold || lu)));
        check_eq("stallD", 32'(stallD), 32'(!br && (hold || lu)));
        check_eq("stallE", 32'(stallE), 32'(!br && hold));
        check_eq("flushD", 32'(flushD), 32'(br));
        check_eq("flushE", 32'(flushE), 32'(br || (!hold && lu)));
        check_eq("flushM", 32'(flushM), 32'(br || hold));
        check_eq("fwdA", 32'(fwdA), 32'(ref_fwd(exe_Rn)));
        check_eq("fwdB", 32'(fwdB), 32'(ref_fwd(exe_Rs)));
        check_eq("trig_start", 32'(trig_start), 32'(st));
        check_eq("trig_abort", 32'(trig_abort), 32'(ab));
        check_eq("trig_error", 32'(trig_error), 32'(m_err));
        check_eq("trig_cycles", 32'(trig_cycles), 32'(m_cyc));
        if (trig_start) start_seen++;
        if (trig_abort) abort_seen++;
        if (stallE) stall_seen++;
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_run = 0; m_cnt = 0; m_err = 0; m_cyc = 0;
        end else if (!m_run) begin
            if (exe_trigSelect && !wb_pcSrc) begin
                m_run = 1; m_cnt = 1;
            end
        end else if (wb_pcSrc) begin
            m_run = 0;
        end else if (trig_done) begin
            m_cyc = m_cnt; m_run = 0;
        end else if (m_cnt >= TO) begin
            m_err = 1; m_run = 0;
        end else begin
            m_cnt++;
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic reset_counts();
        start_seen = 0; abort_seen = 0; stall_seen = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        m_run = 0; m_cnt = 0; m_err = 0; m_cyc = 0;
        @(posedge clk);
        #1;
        exe_trigSelect = 1'b1;
        wb_pcSrc = 1'b1;
        sample();
        check_eq("rst_stallF", 32'(stallF), 32'd0);
        check_eq("rst_flushM", 32'(flushM), 32'd0);
        check_eq("rst_start", 32'(trig_start), 32'd0);
        advance();
        clear_inputs();

        // Forwarding priority
        mem_Rd = 4'd3; wb_Rd = 4'd3; mem_regWrite = 1'b1; wb_regWrite = 1'b1; exe_Rn = 4'd3;
        sample();
        check_eq("fwd_mem_pri", 32'(fwdA), 32'd2);
        advance();
        mem_regWrite = 1'b0;
        sample();
        check_eq("fwd_wb", 32'(fwdA), 32'd1);
        advance();
        clear_inputs();

        // Load-use, then bubble in execute
        exe_regWrite = 1'b1; exe_memToReg = 2'b01; exe_Rd = 4'd5;
        deco_Rs = 4'd5; deco_useRs = 1'b1;
        sample();
        check_eq("lu_stallF", 32'(stallF), 32'd1);
        check_eq("lu_flushE", 32'(flushE), 32'd1);
        advance();
        exe_regWrite = 1'b0; exe_memToReg = 2'b00; exe_Rd = 4'd0;
        sample();
        check_eq("lu_released", 32'(stallF), 32'd0);
        advance();
        exe_regWrite = 1'b1; exe_memToReg = 2'b01; exe_Rd = 4'd5; deco_useRs = 1'b0;
        sample();
        check_eq("lu_unused_src", 32'(stallD), 32'd0);
        advance();
        clear_inputs();

        // Trig op completing 7 cycles after start
        reset_counts();
        exe_trigSelect = 1'b1;
        for (int i = 0; i < 7; i++) cycle();
        trig_done = 1'b1;
        sample();
        check_eq("trig_done_release", 32'(stallE), 32'd0);
        advance();
        trig_done = 1'b0; exe_trigSelect = 1'b0;
        cycle();
        check_eq("trig_start_once", 32'(start_seen), 32'd1);
        check_eq("trig_occupancy", 32'(stall_seen + 1), 32'd8);
        check_eq("trig_cycles_7", 32'(trig_cycles), 32'd7);

        // Back-to-back: done then an immediate new trig instruction
        exe_trigSelect = 1'b1;
        cycle();
        trig_done = 1'b1;
        cycle();
        trig_done = 1'b0;
        sample();
        check_eq("b2b_restart", 32'(trig_start), 32'd1);
        advance();
        trig_done = 1'b1;
        cycle();
        clear_inputs();
        cycle();

        // Timeout
        reset_counts();
        exe_trigSelect = 1'b1;
        for (int i = 0; i < TO + 1; i++) cycle();
        exe_trigSelect = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        check_eq("to_abort_once", 32'(abort_seen), 32'd1);
        check_eq("to_hold_len", 32'(stall_seen), 32'(TO));
        check_eq("to_error_sticky", 32'(trig_error), 32'd1);

        // Branch during RUN
        exe_trigSelect = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        wb_pcSrc = 1'b1;
        sample();
        check_eq("br_flushE", 32'(flushE), 32'd1);
        check_eq("br_stallF", 32'(stallF), 32'd0);
        check_eq("br_abort", 32'(trig_abort), 32'd1);
        advance();
        clear_inputs();
        cycle();

        // Reset mid-RUN, then a normal start
        exe_trigSelect = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        sample();
        check_eq("rstrun_abort", 32'(trig_abort), 32'd0);
        advance();
        rst = 1'b0;
        sample();
        check_eq("rstrun_error", 32'(trig_error), 32'd0);
        check_eq("rstrun_restart", 32'(trig_start), 32'd1);
        advance();
        clear_inputs();
        trig_done = 1'b1;
        cycle();
        trig_done = 1'b0;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 199) == 0);
            deco_Rn        = 4'($urandom_range(0, 5));
            deco_Rs        = 4'($urandom_range(0, 5));
            exe_Rn         = 4'($urandom_range(0, 5));
            exe_Rs         = 4'($urandom_range(0, 5));
            exe_Rd         = 4'($urandom_range(0, 5));
            mem_Rd         = 4'($urandom_range(0, 5));
            wb_Rd          = 4'($urandom_range(0, 5));
            deco_useRn     = 1'($urandom_range(0, 1));
            deco_useRs     = 1'($urandom_range(0, 1));
            exe_regWrite   = 1'($urandom_range(0, 1));
            mem_regWrite   = 1'($urandom_range(0, 1));
            wb_regWrite    = 1'($urandom_range(0, 1));
            exe_memToReg   = 2'($urandom_range(0, 3));
            exe_trigSelect = ($urandom_range(0, 4) == 0);
            trig_done      = ($urandom_range(0, 7) == 0);
            wb_pcSrc       = ($urandom_range(0, 24) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
